// File: rtl/sr_ff_bank.sv
// sr_ff_bank: bank of WIDTH clocked SR flip-flops with per-channel stability filter and sticky conflict reporting
//
// Parameters:
//   WIDTH     number of independent SR channels
//   MODE      S=R=1 policy: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
//   FILTER    extra consecutive stable cycles required before a pair is acted on (0..255)
//   RESET_VAL per-channel value of q after reset
//   CNT_W     width of the saturating error counter
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   s, r         per-channel set / reset requests
//   clr_conflict synchronous clear of conflict and err_cnt (a concurrent qualified 11 wins)
//   q, qbar      channel state and its inverse
//   conflict     sticky per-channel flag for a qualified S=R=1
//   err_cnt      saturating count of cycles with any qualified S=R=1
//
// Build option: define SR_ERR_CNT_EN to build the err_cnt counter; otherwise err_cnt is tied to 0.
module sr_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter int               MODE      = 0,
    parameter int               FILTER    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_conflict,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [7:0] FMAX = 8'(FILTER);

    logic [WIDTH-1:0] q_q, q_d, conflict_q, conflict_d;
    logic [WIDTH-1:0] same, qual, hit;
    logic [1:0]       prev_q [WIDTH];
    logic [1:0]       prev_d [WIDTH];
    logic [7:0]       cnt_q  [WIDTH];
    logic [7:0]       cnt_d  [WIDTH];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            prev_d[i]     = {s[i], r[i]};
            same[i]       = prev_d[i] == prev_q[i];
            cnt_d[i]      = !same[i] ? 8'd0 : cnt_q[i] == FMAX ? FMAX : cnt_q[i] + 8'd1;
            // an unfiltered bank acts on every sample without looking at history
            qual[i]       = FILTER == 0 || (same[i] && cnt_q[i] == FMAX);
            hit[i]        = qual[i] && s[i] && r[i];
            q_d[i]        = (!qual[i] || (!s[i] && !r[i])) ? q_q[i] :
                            (s[i] ^ r[i]) ? s[i] :
                            MODE == 1 ? 1'b1 : MODE == 2 ? 1'b0 : MODE == 3 ? ~q_q[i] : q_q[i];
            conflict_d[i] = hit[i] | (conflict_q[i] & ~clr_conflict);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q        <= RESET_VAL;
            conflict_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                prev_q[i] <= 2'b00;
                cnt_q[i]  <= 8'd0;
            end
        end else begin
            q_q        <= q_d;
            conflict_q <= conflict_d;
            for (int i = 0; i < WIDTH; i++) begin
                prev_q[i] <= prev_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign q        = q_q;
    assign qbar     = ~q_q;
    assign conflict = conflict_q;

`ifdef SR_ERR_CNT_EN
    logic [CNT_W-1:0] err_q, err_d;
    logic             any_hit;

    assign any_hit = |hit;
    // a clear coinciding with a conflict cycle restarts the count at 1
    assign err_d   = clr_conflict ? {{(CNT_W-1){1'b0}}, any_hit} :
                     (any_hit && !(&err_q)) ? err_q + CNT_W'(1) : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= err_d;
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank: directed scoreboard bench for sr_ff_bank across MODE, FILTER and CNT_W variants
module tb_sr_ff_bank;
    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] exp;
        string      name;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic [3:0] s = '0, r = '0;
    logic [3:0] q0, qb0, c0, q1, qb1, c1, q2, qb2, c2, q3, qb3, c3, q4, qb4, c4, q5, qb5, c5;
    logic [7:0] e0, e1, e2, e3, e4;
    logic [1:0] e5;
    int         cyc = 0, errors = 0, checks = 0;
    exp_t       sb[$];
    event       probe;

    sr_ff_bank #(.WIDTH(4), .MODE(0), .FILTER(0), .RESET_VAL(4'b1010), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_conflict(clr),
        .q(q0), .qbar(qb0), .conflict(c0), .err_cnt(e0));
    sr_ff_bank #(.WIDTH(4), .MODE(1), .FILTER(0), .RESET_VAL(4'b0000), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_conflict(clr),
        .q(q1), .qbar(qb1), .conflict(c1), .err_cnt(e1));
    sr_ff_bank #(.WIDTH(4), .MODE(2), .FILTER(0), .RESET_VAL(4'b0000), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_conflict(clr),
        .q(q2), .qbar(qb2), .conflict(c2), .err_cnt(e2));
    sr_ff_bank #(.WIDTH(4), .MODE(3), .FILTER(0), .RESET_VAL(4'b0000), .CNT_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_conflict(clr),
        .q(q3), .qbar(qb3), .conflict(c3), .err_cnt(e3));
    sr_ff_bank #(.WIDTH(4), .MODE(0), .FILTER(2), .RESET_VAL(4'b0000), .CNT_W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_conflict(clr),
        .q(q4), .qbar(qb4), .conflict(c4), .err_cnt(e4));
    sr_ff_bank #(.WIDTH(4), .MODE(0), .FILTER(0), .RESET_VAL(4'b0000), .CNT_W(2)) u5 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_conflict(clr),
        .q(q5), .qbar(qb5), .conflict(c5), .err_cnt(e5));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ev(input int x);
`ifdef SR_ERR_CNT_EN
        return 8'(x);
`else
        return 8'(0 * x);
`endif
    endfunction

    function automatic logic [7:0] act(input int sel);
        case (sel)
            0:       return {4'b0, q0};
            1:       return {4'b0, qb0};
            2:       return {4'b0, c0};
            3:       return e0;
            4:       return {4'b0, q1};
            5:       return {4'b0, q2};
            6:       return {4'b0, q3};
            7:       return {4'b0, q4};
            8:       return {6'b0, e5};
            9:       return {4'b0, c3};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic push(input int c, input int sel, input logic [7:0] v, input string n);
        exp_t e;
        e.cyc = c; e.sel = sel; e.exp = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic expect_next(input int sel, input logic [7:0] v, input string n);
        push(cyc + 1, sel, v, n);
    endtask

    task automatic step(input logic [3:0] ss, input logic [3:0] rr, input logic cc);
        @(negedge clk);
        s = ss; r = rr; clr = cc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        s = '0; r = '0; clr = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or probe);
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (act(e.sel) !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %b want %b (cycle %0d)", e.name, act(e.sel), e.exp, cyc);
                end
            end
        end
    end

    initial begin : driver
        do_reset();
        step(4'b0001, 4'b0000, 1'b0);
        expect_next(0, 8'b1011, "set_ch0_q");
        expect_next(1, 8'b0100, "set_ch0_qbar");
        expect_next(2, 8'b0000, "set_ch0_conflict");
        step(4'b0000, 4'b0001, 1'b0);
        expect_next(0, 8'b1010, "rst_ch0_q");
        step(4'b0001, 4'b0001, 1'b0);
        expect_next(0, 8'b1010, "hold11_q");
        expect_next(2, 8'b0001, "hold11_conflict");
        expect_next(3, ev(1), "hold11_err");
        step(4'b0101, 4'b1010, 1'b0);
        expect_next(0, 8'b0101, "multi_q");
        expect_next(2, 8'b0001, "sticky_conflict");
        @(negedge clk);
        s = '0; r = '0;
        #2 rst_n = 1'b0;
        push(cyc, 0, 8'b1010, "async_rst_q");
        push(cyc, 1, 8'b0101, "async_rst_qbar");
        push(cyc, 2, 8'b0000, "async_rst_conflict");
        push(cyc, 3, 8'b0000, "async_rst_err");
        #1 -> probe;
        @(negedge clk);
        rst_n = 1'b1;

        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step(4'b1111, 4'b1111, 1'b0);
            expect_next(4, 8'b1111, $sformatf("mode1_q_%0d", k));
            expect_next(5, 8'b0000, $sformatf("mode2_q_%0d", k));
            expect_next(6, (k % 2) ? 8'b1111 : 8'b0000, $sformatf("mode3_q_%0d", k));
            expect_next(9, 8'b1111, $sformatf("mode3_conflict_%0d", k));
            expect_next(0, 8'b1010, $sformatf("mode0_q_%0d", k));
            expect_next(3, ev(k), $sformatf("err_cnt_%0d", k));
            expect_next(8, ev(k > 3 ? 3 : k), $sformatf("err_sat_%0d", k));
        end
        step(4'b0000, 4'b0000, 1'b1);
        expect_next(2, 8'b0000, "clr_conflict");
        expect_next(3, 8'b0000, "clr_err");
        expect_next(8, 8'b0000, "clr_err_sat");
        step(4'b0100, 4'b0100, 1'b1);
        expect_next(2, 8'b0100, "clr_vs_set_conflict");
        expect_next(3, ev(1), "clr_vs_set_err");
        expect_next(0, 8'b1010, "clr_vs_set_q");
        step(4'b0000, 4'b0000, 1'b0);
        expect_next(2, 8'b0100, "after_clr_conflict");
        expect_next(3, ev(1), "after_clr_err");

        do_reset();
        for (int k = 1; k <= 3; k++) begin
            step(4'b0010, 4'b0000, 1'b0);
            expect_next(7, 8'b0000, $sformatf("filt_short_%0d", k));
        end
        step(4'b0000, 4'b0000, 1'b0);
        expect_next(7, 8'b0000, "filt_drop");
        for (int k = 1; k <= 4; k++) begin
            step(4'b0010, 4'b0000, 1'b0);
            expect_next(7, (k == 4) ? 8'b0010 : 8'b0000, $sformatf("filt_long_%0d", k));
        end
        step(4'b0000, 4'b0010, 1'b0);
        expect_next(7, 8'b0010, "filt_clr_pending");

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sr_ff_bank.md
# sr_ff_bank

Parametrised bank of clocked SR flip-flops, the multi-channel successor to the single-bit SR flip-flop. Each of `WIDTH` channels has its own S/R pair, a selectable policy for the S=R=1 condition, an optional input-stability filter, and sticky conflict reporting. It is used wherever the design needs a group of set/reset status bits driven from noisy or independently timed sources.

## Interface
- `WIDTH`, 8: number of independent SR channels (≥1).
- `MODE`, 0: S=R=1 policy for all channels. 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle.
- `FILTER`, 0: extra consecutive cycles an S/R pair must be stable before it is acted on. 0 = unfiltered, max 255.
- `RESET_VAL`, {WIDTH{1'b0}}: per-channel value of `q` after reset.
- `CNT_W`, 8: width of the error counter (≥2).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `s` in WIDTH: per-channel set request.
- `r` in WIDTH: per-channel reset request.
- `clr_conflict` in 1: synchronous clear of `conflict` and `err_cnt`.
- `q` out WIDTH: channel state.
- `qbar` out WIDTH: always the bitwise inverse of `q`, including during reset.
- `conflict` out WIDTH: sticky per-channel flag for a qualified S=R=1.
- `err_cnt` out CNT_W: saturating count of cycles with any qualified S=R=1. Functional only with `SR_ERR_CNT_EN`.

## Operation
- Each channel keeps `prev[i]`, the {s,r} pair sampled at the last edge, and `cnt[i]`, 0..FILTER.
- At each edge: if {s[i],r[i]} ≠ prev[i], then cnt[i] ← 0. Otherwise cnt[i] ← min(cnt[i]+1, FILTER). In both cases prev[i] ← {s[i],r[i]}.
- The pair is *qualified* at an edge when it equals prev[i] and cnt[i] == FILTER. It is also qualified when FILTER == 0, with no comparison made.
- A qualified command updates q[i] at that same edge:
  - 00 holds.
  - 10 sets q[i] to 1.
  - 01 clears q[i] to 0.
  - 11 follows `MODE`: hold, 1, 0, or ~q.
- An unqualified pair holds q[i].
- A qualified command keeps applying on every edge while the pair stays stable. In toggle mode, 11 therefore toggles every cycle.
- A qualified 11 sets conflict[i] in every `MODE`.
- `clr_conflict` clears all `conflict` bits. If a channel has a qualified 11 in the same cycle, that bit is set, not cleared (set wins).
- `err_cnt` increments by 1 per cycle with at least one qualified 11 on any channel. It saturates at all-ones. If `clr_conflict` is asserted in the same cycle, it loads 1 instead of clearing (set wins).

## Timing
- Reset (`rst_n` low, asynchronous, immediate):
  - q = RESET_VAL, qbar = ~RESET_VAL.
  - conflict = 0, err_cnt = 0.
  - prev = 00, cnt = 0.
- Reset asserted mid-filter discards all partial qualification.
- First active edge after `rst_n` rises behaves normally.
- Latency with FILTER == 0: q changes at the first edge that samples the pair.
- Latency with FILTER == F: q changes at the (F+2)th consecutive edge that samples the same pair.
  - The first sample loads prev and zeroes cnt.
  - The next F samples count cnt up to F.
  - The following sample qualifies.
- A single-cycle change of the pair restarts qualification for that channel only. Channels are fully independent.
- All outputs are registered (qbar is the inverted register), with no combinational input-to-output paths.

## Configuration
- `SR_ERR_CNT_EN` defined: the `err_cnt` counter and its logic are compiled in as specified above.
- `SR_ERR_CNT_EN` undefined: no counter logic is built, and `err_cnt` is tied to 0. The port list is unchanged.
- `conflict` behaviour is identical in both builds.

## Test plan
- Reset, WIDTH=4, RESET_VAL=4'b1010: hold `rst_n` low mid-cycle -> q=1010 and qbar=0101 immediately, conflict=0, err_cnt=0.
- FILTER=0, MODE=0, channel 0: drive s=1,r=0 for 1 cycle -> q[0]=1 at that edge. Then s=0,r=1 -> q[0]=0 next edge. Then 11 -> q[0] holds and conflict[0]=1.
- MODE sweep with a constant qualified 11 for 3 edges starting at q=0:
  - MODE 1 -> q=1.
  - MODE 2 -> q=0.
  - MODE 3 -> q toggles 1,0,1.
- FILTER=2, channel 1: s=1 for 3 edges then drop -> q[1] stays 0. s=1 held for 4 edges -> q[1]=1 at the 4th edge, and other channels are unchanged.
- Conflict/clear: qualified 11 on channel 2 for 5 cycles with `SR_ERR_CNT_EN` -> err_cnt=5. Pulse `clr_conflict` with no 11 -> conflict=0, err_cnt=0. Pulse it during a qualified 11 -> conflict[2]=1, err_cnt=1.
- Saturation, CNT_W=2: qualified 11 for 6 cycles -> err_cnt holds at 3. Same test without the macro -> err_cnt=0 throughout.
